// File: rtl/dispatch_pkg.sv
// Shared constants and types for the instruction dispatch queue.
package dispatch_pkg;

  // Default instruction word width.
  localparam int INST_W_DEF = 26;

  // Destination channel indices; channels above CH_VECTOR are reserved.
  localparam int CH_SCALAR = 0;
  localparam int CH_VECTOR = 1;

  typedef logic [INST_W_DEF-1:0] inst_t;

endpackage

// File: rtl/chan_fifo.sv
// Single-channel FIFO: no bypass on empty, no pass-through on full.
// clr drops all entries next cycle and ignores any push/pop in that cycle.
module chan_fifo
  import dispatch_pkg::*;
#(
  parameter int W     = INST_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty = (count_r == {CNT_W{1'b0}});
  assign full  = (count_r == FULL_CNT);
  assign count = count_r;

  // Qualify push/pop: refuse push when full, pop when empty, both on clear.
  always_comb begin
    push_ok_s = push & ~full & ~clr & ~rst;
    pop_ok_s  = pop & ~empty & ~clr & ~rst;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Head word, forced to zero when empty so the output is never stale or X.
  always_comb begin
    if (empty) begin
      dout = {W{1'b0}};
    end else begin
      dout = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/inst_dispatch_queue.sv
// Instruction dispatcher: steers each accepted instruction into one of
// NUM_CH per-channel FIFOs by in_sel; out-of-range selects are dropped and
// reported on sel_err one cycle later.
module inst_dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INST_W-1:0]              in_inst,
  input  logic [SEL_W-1:0]               in_sel,
  output logic [NUM_CH-1:0]              out_valid,
  input  logic [NUM_CH-1:0]              out_ready,
  output logic [NUM_CH-1:0][INST_W-1:0]  out_inst,
  output logic [NUM_CH-1:0][CNT_W-1:0]   ch_count,
  output logic                           sel_err
);

  localparam logic [SEL_W:0] NUM_CH_V = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] full_vec_s;
  logic [NUM_CH-1:0] empty_vec_s;
  logic [NUM_CH-1:0] push_vec_s;
  logic [NUM_CH-1:0] pop_vec_s;
  logic              sel_ok_s;
  logic              sel_full_s;
  logic              accept_s;
  logic              sel_err_r;

  // Select decode and full-flag mux for the addressed channel.
  always_comb begin
    sel_ok_s   = ({1'b0, in_sel} < NUM_CH_V);
    sel_full_s = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_full_s = sel_full_s | (full_vec_s[c] & (in_sel == SEL_W'(c)));
    end
  end

  // A bad select never stalls upstream; in_ready ignores in_valid.
  assign in_ready = ~flush & ~rst & (~sel_ok_s | ~sel_full_s);
  assign accept_s = in_valid & in_ready;

  // Discarded-select pulse; accept_s already excludes flush and reset cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= accept_s & ~sel_ok_s;
    end
  end

  assign sel_err = sel_err_r;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push_vec_s[c] = accept_s & sel_ok_s & (in_sel == SEL_W'(c));
    assign pop_vec_s[c]  = out_ready[c] & ~empty_vec_s[c];
    assign out_valid[c]  = ~empty_vec_s[c];

    chan_fifo #(
      .W     (INST_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push_vec_s[c]),
      .din   (in_inst),
      .pop   (pop_vec_s[c]),
      .dout  (out_inst[c]),
      .empty (empty_vec_s[c]),
      .full  (full_vec_s[c]),
      .count (ch_count[c])
    );
  end

endmodule

// File: tb/tb_inst_dispatch_queue.sv
// Self-checking bench: directed steps plus a random phase, checked against
// per-channel reference queues. A second 3-channel instance covers bad selects.
module tb_inst_dispatch_queue;
  import dispatch_pkg::*;

  localparam int W = 26;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: NUM_CH = 2
  logic            rst, flush, in_valid, in_ready, sel_err;
  logic [W-1:0]    in_inst;
  logic [0:0]      in_sel;
  logic [1:0]      out_valid, out_ready;
  logic [1:0][W-1:0] out_inst;
  logic [1:0][2:0] ch_count;

  // Second instance: NUM_CH = 3
  logic            b_flush, b_in_valid, b_in_ready, b_sel_err;
  logic [W-1:0]    b_in_inst;
  logic [1:0]      b_in_sel;
  logic [2:0]      b_out_valid, b_out_ready;
  logic [2:0][W-1:0] b_out_inst;
  logic [2:0][2:0] b_ch_count;

  inst_dispatch_queue #(.INST_W(W), .NUM_CH(2), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .ch_count(ch_count), .sel_err(sel_err)
  );

  inst_dispatch_queue #(.INST_W(W), .NUM_CH(3), .DEPTH(D)) dut3 (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inst(b_in_inst), .in_sel(b_in_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_inst(b_out_inst), .ch_count(b_ch_count), .sel_err(b_sel_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel of the main instance.
  logic [W-1:0] mq [2][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("out_valid[%0d]", c), 64'(out_valid[c]), 64'(mq[c].size() > 0));
      chk($sformatf("out_inst[%0d]", c), 64'(out_inst[c]),
          (mq[c].size() > 0) ? 64'(mq[c][0]) : 64'd0);
      chk($sformatf("ch_count[%0d]", c), 64'(ch_count[c]), 64'(mq[c].size()));
    end
    chk("sel_err", 64'(sel_err), 64'd0);
  endtask

  // One clock of the main instance with inputs already driven at the negedge.
  task automatic cyc();
    logic exp_ready;
    logic acc;
    #1;
    exp_ready = !rst && !flush && (mq[in_sel].size() < D);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    acc = in_valid && exp_ready;
    @(posedge clk);
    if (rst || flush) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (out_ready[c] && mq[c].size() > 0) begin
          void'(mq[c].pop_front());
        end
      end
      if (acc) mq[in_sel].push_back(in_inst);
    end
    @(negedge clk);
    chk_outputs();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    logic [W-1:0] seq_w [5];
    logic [0:0]   seq_s [5];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_sel = '0; out_ready = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_inst = '0; b_in_sel = '0; b_out_ready = '0;
    repeat (3) @(negedge clk);

    // Reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_ch_count", 64'(ch_count), 64'd0);
    chk("rst_sel_err", 64'(sel_err), 64'd0);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single push to the scalar channel, visible one cycle later
    in_valid = 1'b1; in_sel = 1'(CH_SCALAR); in_inst = 26'h0ABCDEF;
    cyc();
    chk("t1_out_valid", 64'(out_valid), 64'b01);
    chk("t1_out_inst0", 64'(out_inst[0]), 64'h0ABCDEF);
    chk("t1_ch_count0", 64'(ch_count[0]), 64'd1);
    chk("t1_out_inst1", 64'(out_inst[1]), 64'd0);
    out_ready = 2'b11;
    idle(2);

    // Stalled vector channel: 4 accepted, 5th refused, scalar still open
    out_ready = 2'b00;
    in_valid = 1'b1; in_sel = 1'(CH_VECTOR);
    for (int i = 0; i < 5; i++) begin
      in_inst = 26'(32'h100 + i);
      if (i == 4) begin
        #1 chk("t2_in_ready_full", 64'(in_ready), 64'd0);
      end
      cyc();
    end
    chk("t2_ch_count1", 64'(ch_count[1]), 64'd4);
    in_sel = 1'(CH_SCALAR); in_inst = 26'h55;
    #1 chk("t2_ch0_ready", 64'(in_ready), 64'd1);
    cyc();
    out_ready = 2'b11;
    idle(6);

    // Interleaved pushes drain per channel in order, one cycle after accept
    seq_w[0] = 26'h1; seq_s[0] = 1'b0;
    seq_w[1] = 26'hA; seq_s[1] = 1'b1;
    seq_w[2] = 26'h2; seq_s[2] = 1'b0;
    seq_w[3] = 26'hB; seq_s[3] = 1'b1;
    seq_w[4] = 26'h3; seq_s[4] = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_sel = seq_s[i]; in_inst = seq_w[i];
      cyc();
      chk("t3_head", 64'(out_inst[seq_s[i]]), 64'(seq_w[i]));
    end
    idle(2);

    // Flush with a valid input in the same cycle
    out_ready = 2'b00; in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_inst = 26'(32'h200 + i);
      cyc();
    end
    chk("t5_pre_count", 64'(ch_count[0]), 64'd3);
    flush = 1'b1; in_inst = 26'h3FFFFFF;
    #1 chk("t5_flush_ready", 64'(in_ready), 64'd0);
    cyc();
    flush = 1'b0;
    chk("t5_count", 64'(ch_count), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    idle(1);
    chk("t5_not_stored", 64'(out_valid), 64'd0);

    // Full channel popping: push refused, then accepted next cycle
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_inst = 26'(32'h300 + i);
      cyc();
    end
    out_ready = 2'b01; in_inst = 26'h3AA;
    #1 chk("t6_ready_full", 64'(in_ready), 64'd0);
    cyc();
    chk("t6_count", 64'(ch_count[0]), 64'd3);
    out_ready = 2'b00;
    #1 chk("t6_ready_next", 64'(in_ready), 64'd1);
    cyc();
    chk("t6_count_after", 64'(ch_count[0]), 64'd4);

    // Reset mid-operation clears everything
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_count", 64'(ch_count), 64'd0);
    idle(1);

    // Three-channel instance: bad select, reserved channel, flush suppression
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_inst = 26'h123;
    #1 chk("b_bad_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_sel_err_hi", 64'(b_sel_err), 64'd1);
    chk("b_nothing_queued", 64'(b_out_valid), 64'd0);
    chk("b_counts_zero", 64'(b_ch_count), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("b_sel_err_lo", 64'(b_sel_err), 64'd0);
    b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_inst = 26'h2C2C2C;
    #1 chk("b_ch2_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_ch2_valid", 64'(b_out_valid), 64'b100);
    chk("b_ch2_inst", 64'(b_out_inst[2]), 64'h2C2C2C);
    chk("b_no_err", 64'(b_sel_err), 64'd0);
    b_out_ready = 3'b100;
    @(posedge clk); @(negedge clk);
    chk("b_ch2_popped", 64'(b_out_valid), 64'd0);
    b_flush = 1'b1; b_in_valid = 1'b1; b_in_sel = 2'd3;
    #1 chk("b_flush_ready", 64'(b_in_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    b_flush = 1'b0; b_in_valid = 1'b0;
    chk("b_flush_no_err", 64'(b_sel_err), 64'd0);

    // Random traffic on the main instance
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(63) == 0);
      flush     = ($urandom_range(31) == 0);
      in_valid  = 1'($urandom_range(1));
      in_sel    = 1'($urandom_range(1));
      in_inst   = 26'($urandom);
      out_ready = 2'($urandom_range(3));
      cyc();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
